// File: rtl/cfg_flit_dispatch_if.sv
// Bundle of the three flit channels around cfg_flit_dispatch:
//   - router ingress (flit_in_valid / flit_in_data / flit_in_ready)
//   - config controller egress (spk_in_config_we / spk_in_config_wdata,
//     with credits returned on config_spk_in_credit)
//   - axon path egress (axon_valid / axon_data / axon_ready)
// The slave modport is the dispatcher's view; master is the surrounding
// environment (router, config controller, axon path).
interface cfg_flit_dispatch_if #(
  parameter int FW = 59
);
  logic          flit_in_valid;
  logic [FW-1:0] flit_in_data;
  logic          flit_in_ready;
  logic          spk_in_config_we;
  logic [FW-1:0] spk_in_config_wdata;
  logic          config_spk_in_credit;
  logic          axon_valid;
  logic [FW-1:0] axon_data;
  logic          axon_ready;

  modport slave (
    input  flit_in_valid, flit_in_data, config_spk_in_credit, axon_ready,
    output flit_in_ready, spk_in_config_we, spk_in_config_wdata,
           axon_valid, axon_data
  );

  modport master (
    output flit_in_valid, flit_in_data, config_spk_in_credit, axon_ready,
    input  flit_in_ready, spk_in_config_we, spk_in_config_wdata,
           axon_valid, axon_data
  );
endinterface

// File: rtl/cfg_flit_dispatch.sv
// Ingress dispatcher in front of the node configuration controller.
// Router flits are buffered in a DEPTH-entry FIFO and served strictly in
// order. The head flit's type field steers it:
//   WRITE/READ          -> config controller, one pulse per flit, credit gated
//   SPIKE/DATA/DATA_END -> axon path through a registered valid/ready slice
//   anything else       -> dropped and counted (saturating)
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         cfg_flit_dispatch_if.slave (ingress, config and axon channels)
//   drop_cnt    saturating count of dropped flits
//   credit_err  sticky: credit returned while the counter was already full
module cfg_flit_dispatch #(
  parameter int FW      = 59,
  parameter int FTW     = 3,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 1,
  parameter int DCW     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cfg_flit_dispatch_if.slave bus,
  output logic [DCW-1:0]     drop_cnt,
  output logic               credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]  CREDITS_C = CW'(CREDITS);
  localparam logic [DCW-1:0] DROP_MAX  = {DCW{1'b1}};

  typedef enum logic [1:0] {
    CLS_AXON = 2'd0,
    CLS_CFG  = 2'd1,
    CLS_DROP = 2'd2
  } cls_e;

  function automatic cls_e decode_type(input logic [FTW-1:0] t);
    cls_e c;
    case (t)
      FTW'(0), FTW'(1), FTW'(2): c = CLS_AXON;
      FTW'(6), FTW'(7):          c = CLS_CFG;
      default:                   c = CLS_DROP;
    endcase
    return c;
  endfunction

  logic [FW-1:0]  mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic [CW-1:0]  credit_r;
  logic           cfg_we_r;
  logic [FW-1:0]  cfg_wdata_r;
  logic           axon_valid_r;
  logic [FW-1:0]  axon_data_r;
  logic [DCW-1:0] drop_cnt_r;
  logic           credit_err_r;

  logic [FW-1:0]  head_s;
  cls_e           head_cls_s;
  logic           empty_s;
  logic           full_s;
  logic           push_s;
  logic           cfg_pop_s;
  logic           axon_pop_s;
  logic           drop_pop_s;
  logic           pop_s;

  // Head decode and the single pop decision; only one class can match.
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    head_cls_s = decode_type(head_s[FW-1 -: FTW]);
    empty_s    = (count_r == '0);
    full_s     = (count_r == DEPTH_C);
    push_s     = bus.flit_in_valid && !full_s;
    cfg_pop_s  = 1'b0;
    axon_pop_s = 1'b0;
    drop_pop_s = 1'b0;
    if (!empty_s) begin
      case (head_cls_s)
        CLS_CFG:  cfg_pop_s  = (credit_r != '0);
        CLS_AXON: axon_pop_s = !axon_valid_r || bus.axon_ready;
        CLS_DROP: drop_pop_s = 1'b1;
        default:  drop_pop_s = 1'b1;
      endcase
    end else begin
      cfg_pop_s  = 1'b0;
    end
    pop_s = cfg_pop_s || axon_pop_s || drop_pop_s;
  end

  // FIFO storage, wrapping pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.flit_in_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit counter; a return that would overflow is flagged, not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r     <= CREDITS_C;
      credit_err_r <= 1'b0;
    end else begin
      case ({cfg_pop_s, bus.config_spk_in_credit})
        2'b10: credit_r <= credit_r - CW'(1);
        2'b01: begin
          if (credit_r == CREDITS_C) begin
            credit_err_r <= 1'b1;
          end else begin
            credit_r <= credit_r + CW'(1);
          end
        end
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Config egress: one-cycle write pulse after the pop; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_we_r    <= 1'b0;
      cfg_wdata_r <= '0;
    end else begin
      cfg_we_r <= cfg_pop_s;
      if (cfg_pop_s) begin
        cfg_wdata_r <= head_s;
      end
    end
  end

  // Axon output slice: reload on pop, otherwise clear once the flit is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axon_valid_r <= 1'b0;
      axon_data_r  <= '0;
    end else if (axon_pop_s) begin
      axon_valid_r <= 1'b1;
      axon_data_r  <= head_s;
    end else if (bus.axon_ready) begin
      axon_valid_r <= 1'b0;
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
    end else if (drop_pop_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + DCW'(1);
    end
  end

  assign bus.flit_in_ready       = !full_s;
  assign bus.spk_in_config_we    = cfg_we_r;
  assign bus.spk_in_config_wdata = cfg_wdata_r;
  assign bus.axon_valid          = axon_valid_r;
  assign bus.axon_data           = axon_data_r;
  assign drop_cnt                = drop_cnt_r;
  assign credit_err              = credit_err_r;

endmodule

// File: tb/tb_cfg_flit_dispatch.sv
// Directed bench for cfg_flit_dispatch. Inputs change 1 ns after each rising
// edge, outputs are sampled at the same point, so a value checked right after
// tick() is the value held during the cycle that just started.
module tb_cfg_flit_dispatch;

  localparam int FW = 59;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] drop_cnt;
  logic credit_err;
  int tests_run = 0;
  int tests_failed = 0;

  cfg_flit_dispatch_if #(.FW(FW)) bus ();

  cfg_flit_dispatch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .drop_cnt   (drop_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [2:0] t, input logic [55:0] p);
    return {t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flit_in_valid        = 1'b0;
    bus.flit_in_data         = '0;
    bus.config_spk_in_credit = 1'b0;
    bus.axon_ready           = 1'b0;
  endtask

  task automatic push(input logic [FW-1:0] f);
    bus.flit_in_valid = 1'b1;
    bus.flit_in_data  = f;
    tick();
    bus.flit_in_valid = 1'b0;
  endtask

  task automatic credit_pulse();
    bus.config_spk_in_credit = 1'b1;
    tick();
    bus.config_spk_in_credit = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus.flit_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %0b want 1", bus.flit_in_ready);
    end
    tests_run++;
    if (bus.spk_in_config_we !== 1'b0 || bus.spk_in_config_wdata !== '0) begin
      tests_failed++; $display("FAIL reset_cfg: got we=%0b wdata=%h want 0/0",
                               bus.spk_in_config_we, bus.spk_in_config_wdata);
    end
    tests_run++;
    if (bus.axon_valid !== 1'b0 || bus.axon_data !== '0) begin
      tests_failed++; $display("FAIL reset_axon: got v=%0b d=%h want 0/0",
                               bus.axon_valid, bus.axon_data);
    end
    tests_run++;
    if (drop_cnt !== 8'd0 || credit_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_cnt: got drop=%0d err=%0b want 0/0", drop_cnt, credit_err);
    end
  endtask

  // WRITE pushed in cycle 0 -> we in cycle 2; second WRITE waits for the credit in cycle 5 -> we in cycle 7.
  task automatic test_cfg_write();
    logic [FW-1:0] w1, w2;
    w1 = mk(3'b110, 56'h00_0000_0000_00A5);
    w2 = mk(3'b110, 56'h12_3456_789A_BC5A);
    bus.flit_in_valid = 1'b1; bus.flit_in_data = w1;
    tick();                                   // cycle 1
    tests_run++;
    if (bus.spk_in_config_we !== 1'b0) begin
      tests_failed++; $display("FAIL cfg_we_c1: got %0b want 0", bus.spk_in_config_we);
    end
    bus.flit_in_data = w2;
    tick();                                   // cycle 2
    bus.flit_in_valid = 1'b0;
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== w1) begin
      tests_failed++; $display("FAIL cfg_we_c2: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, w1);
    end
    for (int c = 3; c <= 5; c++) begin
      tick();                                 // cycles 3..5
      tests_run++;
      if (bus.spk_in_config_we !== 1'b0) begin
        tests_failed++; $display("FAIL cfg_stall_c%0d: got we=%0b want 0", c, bus.spk_in_config_we);
      end
    end
    bus.config_spk_in_credit = 1'b1;          // credit in cycle 5
    tick();                                   // cycle 6
    bus.config_spk_in_credit = 1'b0;
    tests_run++;
    if (bus.spk_in_config_we !== 1'b0) begin
      tests_failed++; $display("FAIL cfg_we_c6: got %0b want 0", bus.spk_in_config_we);
    end
    tick();                                   // cycle 7
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== w2) begin
      tests_failed++; $display("FAIL cfg_we_c7: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, w2);
    end
    tick();                                   // cycle 8: pulse over, data held
    tests_run++;
    if (bus.spk_in_config_we !== 1'b0 || bus.spk_in_config_wdata !== w2) begin
      tests_failed++; $display("FAIL cfg_hold_c8: got we=%0b d=%h want 0/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, w2);
    end
    credit_pulse();                           // restore credit to 1
  endtask

  // Four spikes under backpressure, fifth fills the FIFO, then drain 1/cycle.
  task automatic test_axon_backpressure();
    logic [FW-1:0] s [5];
    for (int i = 0; i < 5; i++) s[i] = mk((i == 4) ? 3'b010 : 3'b000, 56'h5000 + 56'(i));
    bus.axon_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(s[i]);
    tests_run++;
    if (bus.axon_valid !== 1'b1 || bus.axon_data !== s[0] || bus.flit_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL axon_hold: got v=%0b d=%h rdy=%0b want 1/%h/1",
                               bus.axon_valid, bus.axon_data, bus.flit_in_ready, s[0]);
    end
    push(s[4]);
    tests_run++;
    if (bus.flit_in_ready !== 1'b0 || bus.axon_data !== s[0]) begin
      tests_failed++; $display("FAIL axon_full: got rdy=%0b d=%h want 0/%h",
                               bus.flit_in_ready, bus.axon_data, s[0]);
    end
    push(mk(3'b001, 56'hDEAD));               // offered while full: must be ignored
    bus.axon_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      tests_run++;
      if (bus.axon_valid !== 1'b1 || bus.axon_data !== s[i]) begin
        tests_failed++; $display("FAIL axon_drain%0d: got v=%0b d=%h want 1/%h",
                                 i, bus.axon_valid, bus.axon_data, s[i]);
      end
      if (i == 1) begin
        tests_run++;
        if (bus.flit_in_ready !== 1'b1) begin
          tests_failed++; $display("FAIL axon_ready_back: got %0b want 1", bus.flit_in_ready);
        end
      end
    end
    tick();
    tests_run++;
    if (bus.axon_valid !== 1'b0) begin
      tests_failed++; $display("FAIL axon_empty: got v=%0b d=%h want 0", bus.axon_valid, bus.axon_data);
    end
  endtask

  // READ stalled on zero credit keeps the SPIKE behind it out of the axon path.
  task automatic test_hol();
    logic [FW-1:0] w3, rd, sp;
    w3 = mk(3'b110, 56'h33);
    rd = mk(3'b111, 56'h44);
    sp = mk(3'b000, 56'h55);
    bus.axon_ready = 1'b1;
    push(w3);
    push(rd);
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== w3) begin
      tests_failed++; $display("FAIL hol_w3: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, w3);
    end
    push(sp);
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (bus.axon_valid !== 1'b0 || bus.spk_in_config_we !== 1'b0) begin
        tests_failed++; $display("FAIL hol_stall%0d: got v=%0b we=%0b want 0/0",
                                 c, bus.axon_valid, bus.spk_in_config_we);
      end
      if (c < 3) tick();
    end
    credit_pulse();                           // READ pops this cycle
    tests_run++;
    if (bus.axon_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hol_early: got v=%0b want 0", bus.axon_valid);
    end
    tick();
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== rd || bus.axon_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hol_read: got we=%0b d=%h v=%0b want 1/%h/0",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, bus.axon_valid, rd);
    end
    tick();
    tests_run++;
    if (bus.axon_valid !== 1'b1 || bus.axon_data !== sp) begin
      tests_failed++; $display("FAIL hol_spike: got v=%0b d=%h want 1/%h", bus.axon_valid, bus.axon_data, sp);
    end
    tick();
    credit_pulse();                           // restore credit to 1
  endtask

  // Unknown types: nothing emitted, counter counts and saturates.
  task automatic test_drop();
    bus.axon_ready = 1'b0;
    push(mk(3'b011, 56'h1));
    push(mk(3'b100, 56'h2));
    push(mk(3'b101, 56'h3));
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (bus.axon_valid !== 1'b0 || bus.spk_in_config_we !== 1'b0) begin
        tests_failed++; $display("FAIL drop_quiet%0d: got v=%0b we=%0b want 0/0",
                                 c, bus.axon_valid, bus.spk_in_config_we);
      end
      tick();
    end
    tests_run++;
    if (drop_cnt !== 8'd3) begin
      tests_failed++; $display("FAIL drop_cnt3: got %0d want 3", drop_cnt);
    end
    bus.flit_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.flit_in_data = mk(3'b011 + 3'(i % 3), 56'(i));
      tick();
    end
    bus.flit_in_valid = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (drop_cnt !== 8'd255) begin
      tests_failed++; $display("FAIL drop_sat: got %0d want 255", drop_cnt);
    end
  endtask

  // Return and dispatch in the same cycle keep the counter at 1.
  task automatic test_credit_simul();
    logic [FW-1:0] wa, wb, wc;
    wa = mk(3'b110, 56'hA1);
    wb = mk(3'b111, 56'hB2);
    wc = mk(3'b110, 56'hC3);
    push(wa);                                 // wa pops in this cycle
    credit_pulse();                           // simultaneous return
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== wa) begin
      tests_failed++; $display("FAIL simul_wa: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, wa);
    end
    push(wb);
    tick();
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== wb) begin
      tests_failed++; $display("FAIL simul_wb: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, wb);
    end
    push(wc);
    repeat (2) tick();
    tests_run++;
    if (bus.spk_in_config_we !== 1'b0) begin
      tests_failed++; $display("FAIL simul_wc_stall: got we=%0b want 0", bus.spk_in_config_we);
    end
  endtask

  // Overflowing return sets the sticky flag and leaves the counter at 1.
  task automatic test_credit_err();
    logic [FW-1:0] wc, we_f, wf;
    wc   = mk(3'b110, 56'hC3);
    we_f = mk(3'b110, 56'hE5);
    wf   = mk(3'b111, 56'hF6);
    credit_pulse();                           // releases wc left by the previous test
    tick();
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== wc) begin
      tests_failed++; $display("FAIL err_wc: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, wc);
    end
    credit_pulse();                           // legal return: counter 0 -> 1
    tests_run++;
    if (credit_err !== 1'b0) begin
      tests_failed++; $display("FAIL err_legal: got %0b want 0", credit_err);
    end
    credit_pulse();                           // overflow return
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (credit_err !== 1'b1) begin
        tests_failed++; $display("FAIL err_sticky%0d: got %0b want 1", c, credit_err);
      end
      tick();
    end
    push(we_f);
    tick();
    tests_run++;
    if (bus.spk_in_config_we !== 1'b1 || bus.spk_in_config_wdata !== we_f) begin
      tests_failed++; $display("FAIL err_credit1: got we=%0b d=%h want 1/%h",
                               bus.spk_in_config_we, bus.spk_in_config_wdata, we_f);
    end
    push(wf);
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (bus.spk_in_config_we !== 1'b0) begin
        tests_failed++; $display("FAIL err_no_extra%0d: got we=%0b want 0", c, bus.spk_in_config_we);
      end
    end
    credit_pulse();
    repeat (2) tick();
  endtask

  // Reset while flits are buffered discards them and clears the status.
  task automatic test_mid_reset();
    bus.axon_ready = 1'b0;
    push(mk(3'b000, 56'h71));
    push(mk(3'b001, 56'h72));
    tick();
    tests_run++;
    if (bus.axon_valid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pre: got v=%0b want 1", bus.axon_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.axon_valid !== 1'b0 || drop_cnt !== 8'd0 || credit_err !== 1'b0 || bus.flit_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_rst: got v=%0b drop=%0d err=%0b rdy=%0b want 0/0/0/1",
                               bus.axon_valid, drop_cnt, credit_err, bus.flit_in_ready);
    end
    tick();
    rst_n = 1'b1;
    bus.axon_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.axon_valid !== 1'b0 || bus.spk_in_config_we !== 1'b0) begin
      tests_failed++; $display("FAIL mid_flush: got v=%0b we=%0b want 0/0",
                               bus.axon_valid, bus.spk_in_config_we);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cfg_write();
    test_axon_backpressure();
    test_hol();
    test_drop();
    test_credit_simul();
    test_credit_err();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cfg_flit_dispatch.md
Name: cfg_flit_dispatch

Overview:
- Ingress stage that sits directly upstream of the node configuration controller.
- Accepts flits from the router, buffers them in a small FIFO, and decodes the packet type of the head flit.
- Steers WRITE/READ flits to the configuration controller under one-credit flow control.
- Steers SPIKE/DATA/DATA_END flits to the axon path with a valid/ready handshake.
- Drops unknown packet types and counts them.

Parameters:
- FW, 59, flit width; packet type is in bits [FW-1:FW-FTW].
- FTW, 3, flit type width.
- DEPTH, 4, ingress FIFO depth in flits (power of 2, at least 2).
- CREDITS, 1, initial and maximum number of config credits.
- DCW, 8, drop counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flit_in_valid  in  1  router flit valid
- flit_in_data  in  FW  router flit
- flit_in_ready  out  1  FIFO can accept a flit
- spk_in_config_we  out  1  one-cycle pulse that delivers a flit to the config controller
- spk_in_config_wdata  out  FW  config flit
- config_spk_in_credit  in  1  one-cycle credit return from the config controller
- axon_valid  out  1  spike-path flit valid
- axon_data  out  FW  spike-path flit
- axon_ready  in  1  spike-path accept
- drop_cnt  out  DCW  saturating count of dropped flits
- credit_err  out  1  sticky flag: credit returned while the counter is already at CREDITS

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; credit counter = CREDITS.
  - spk_in_config_we=0, spk_in_config_wdata=0.
  - axon_valid=0, axon_data=0.
  - drop_cnt=0, credit_err=0.
  - flit_in_ready=1 after reset.
  - Reset mid-operation discards all buffered and in-flight flits.
- FIFO:
  - flit_in_ready = !full, derived from registered occupancy.
  - Push when flit_in_valid && flit_in_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - Strict in-order service: a blocked head flit blocks every flit behind it.
- Head decode, evaluated only when the FIFO is non-empty:
  - 000 SPIKE, 001 DATA, 010 DATA_END -> AXON class.
  - 110 WRITE, 111 READ -> CFG class.
  - 011, 100, 101 -> DROP class.
- CFG dispatch (credit>0):
  - Pop the head; in the next cycle spk_in_config_we=1 for exactly one cycle with spk_in_config_wdata = that flit.
  - Credit is decremented in the pop cycle.
  - spk_in_config_wdata holds its last value when we=0.
- CFG dispatch (credit==0): head stalls; no pop, no we.
- Credit return: config_spk_in_credit=1 increments the credit counter.
  - Return and dispatch in the same cycle: counter unchanged.
  - Return while the counter is already CREDITS with no dispatch: counter stays CREDITS and credit_err sets (sticky until reset).
- Credit latency: with CREDITS=1, a credit returned in cycle t allows the next CFG pop in cycle t+1, producing we in cycle t+2.
- AXON path (registered output slice):
  - Load axon_valid/axon_data from the head and pop when the head is AXON class and (!axon_valid || axon_ready).
  - axon_valid drops when axon_ready=1 and nothing is loaded.
  - axon_data is stable while axon_valid && !axon_ready.
  - Back-to-back throughput: 1 flit/cycle.
- DROP: pop the head in one cycle; drop_cnt increments and saturates at 2^DCW-1. Nothing is emitted.
- At most one pop per cycle.

Test Plan:
- Reset check -> flit_in_ready=1, all other outputs 0, credit=1.
- WRITE flit (type 110, payload 0x...A5) pushed in cycle 0 -> popped in cycle 1, spk_in_config_we=1 in cycle 2 with identical data. A second WRITE behind it stalls until config_spk_in_credit is pulsed in cycle 5, then we=1 in cycle 7.
- Four SPIKE flits with axon_ready=0 -> first held on axon_data, remaining three in FIFO. A fifth push fills the FIFO (4 buffered) and flit_in_ready=0. Raising axon_ready drains one flit per cycle in order.
- READ at head with credit=0, followed by a SPIKE -> SPIKE is not delivered until the credit returns (head-of-line ordering).
- Flits of types 011/100/101 -> no outputs emitted, drop_cnt=3. Sending 300 drops -> drop_cnt=255.
- config_spk_in_credit pulsed with no outstanding flit -> credit_err=1 and stays 1, credit stays 1. Simultaneous credit return and CFG pop -> credit unchanged.
